// File: rtl/dual_port_ram_arbiter.sv
// dual_port_ram_arbiter: round-robin sharing of both dual-port RAM ports among NUM_REQ clients.
// Define RAM_ARB_COLLISION_CNT_EN to build the saturating same-address collision counter.
module dual_port_ram_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        we,
    input  logic [NUM_REQ*ADDR_W-1:0] addr,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        rvalid,
    output logic [NUM_REQ*DATA_W-1:0] rdata,
    output logic                      write_en_a,
    output logic                      write_en_b,
    output logic [ADDR_W-1:0]         address_a,
    output logic [ADDR_W-1:0]         address_b,
    output logic [DATA_W-1:0]         data_in_a,
    output logic [DATA_W-1:0]         data_in_b,
    input  logic [DATA_W-1:0]         data_out_a,
    input  logic [DATA_W-1:0]         data_out_b,
    output logic [15:0]               collision_cnt
);
    logic               a_vld, b_vld, hazard, gnt_b;
    logic [IDX_W-1:0]   a_idx, b_idx, last, rr_ptr, rr_nxt;
    logic [ADDR_W-1:0]  a_addr, b_addr;
    logic               tag_a_v, tag_b_v;
    logic [IDX_W-1:0]   tag_a_i, tag_b_i;
    logic [NUM_REQ-1:0] rv_nxt;

    function automatic logic [IDX_W-1:0] wrap(input int v);
        return IDX_W'(v % NUM_REQ);
    endfunction

    always_comb begin
        a_vld = 1'b0;
        b_vld = 1'b0;
        a_idx = '0;
        b_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req[wrap(int'(rr_ptr) + k)]) begin
                if (!a_vld) begin
                    a_vld = 1'b1;
                    a_idx = wrap(int'(rr_ptr) + k);
                end else if (!b_vld) begin
                    b_vld = 1'b1;
                    b_idx = wrap(int'(rr_ptr) + k);
                end
            end
        end
        a_addr = addr[a_idx*ADDR_W +: ADDR_W];
        b_addr = addr[b_idx*ADDR_W +: ADDR_W];
        // port B is left idle rather than handed to a later requester
        hazard = a_vld && b_vld && (a_addr == b_addr) && (we[a_idx] || we[b_idx]);
        gnt_b = b_vld && !hazard;
        gnt = '0;
        if (a_vld) gnt[a_idx] = 1'b1;
        if (gnt_b) gnt[b_idx] = 1'b1;
        last = gnt_b ? b_idx : a_idx;
        rr_nxt = a_vld ? wrap(int'(last) + 1) : rr_ptr;
        write_en_a = a_vld && we[a_idx];
        address_a = a_vld ? a_addr : '0;
        data_in_a = a_vld ? wdata[a_idx*DATA_W +: DATA_W] : '0;
        write_en_b = gnt_b && we[b_idx];
        address_b = gnt_b ? b_addr : '0;
        data_in_b = gnt_b ? wdata[b_idx*DATA_W +: DATA_W] : '0;
        rv_nxt = '0;
        if (tag_a_v) rv_nxt[tag_a_i] = 1'b1;
        if (tag_b_v) rv_nxt[tag_b_i] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr  <= '0;
            tag_a_v <= 1'b0;
            tag_b_v <= 1'b0;
            tag_a_i <= '0;
            tag_b_i <= '0;
            rvalid  <= '0;
            rdata   <= '0;
        end else begin
            rr_ptr  <= rr_nxt;
            tag_a_v <= a_vld && !we[a_idx];
            tag_a_i <= a_idx;
            tag_b_v <= gnt_b && !we[b_idx];
            tag_b_i <= b_idx;
            rvalid  <= rv_nxt;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (tag_a_v && tag_a_i == IDX_W'(i))
                    rdata[i*DATA_W +: DATA_W] <= data_out_a;
                else if (tag_b_v && tag_b_i == IDX_W'(i))
                    rdata[i*DATA_W +: DATA_W] <= data_out_b;
            end
        end
    end

`ifdef RAM_ARB_COLLISION_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            collision_cnt <= '0;
        else if (hazard && collision_cnt != 16'hFFFF)
            collision_cnt <= collision_cnt + 16'd1;
    end
`else
    assign collision_cnt = '0;
`endif
endmodule

// File: tb/tb_dual_port_ram_arbiter.sv
// tb_dual_port_ram_arbiter: directed and random traffic against a queue-based arbitration and memory model.
module tb_dual_port_ram_arbiter;
    localparam int N = 4, AW = 8, DW = 8;
`ifdef RAM_ARB_COLLISION_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic clk = 1'b0, reset = 1'b0;
    logic [N-1:0] req, we, gnt, rvalid;
    logic [N*AW-1:0] addr;
    logic [N*DW-1:0] wdata, rdata;
    logic write_en_a, write_en_b;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] data_in_a, data_in_b;
    logic [DW-1:0] data_out_a = '0, data_out_b = '0;
    logic [15:0] collision_cnt;

    always #5 clk = ~clk;

    dual_port_ram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .IDX_W(2)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
        .write_en_a(write_en_a), .write_en_b(write_en_b),
        .address_a(address_a), .address_b(address_b),
        .data_in_a(data_in_a), .data_in_b(data_in_b),
        .data_out_a(data_out_a), .data_out_b(data_out_b),
        .collision_cnt(collision_cnt)
    );

    logic [7:0] mem [256] = '{default: 8'h00};
    always @(posedge clk) begin
        if (write_en_a) mem[address_a] <= data_in_a;
        if (write_en_b) mem[address_b] <= data_in_b;
        data_out_a <= mem[address_a];
        data_out_b <= mem[address_b];
    end

    logic [7:0] ref_mem [256] = '{default: 8'h00};
    logic [7:0] exp_q [N][$];
    int ref_ptr = 0, exp_coll = 0, checks = 0, failures = 0;
    logic [N-1:0] obs_gnt, obs_rvalid;
    logic [N*DW-1:0] obs_rdata;
    logic [33:0] obs_ports;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] a_of(input int c);
        return addr[c*AW +: AW];
    endfunction

    function automatic logic [DW-1:0] d_of(input int c);
        return wdata[c*DW +: DW];
    endfunction

    // Requesters in rotation order; first two are port candidates unless they conflict.
    task automatic model(input bit upd);
        int order[$];
        logic [N-1:0] eg;
        logic [33:0] ep;
        int a, b, last;
        chk("collision_cnt", collision_cnt, CNT_EN ? exp_coll : 0);
        for (int k = 0; k < N; k++)
            if (req[(ref_ptr + k) % N]) order.push_back((ref_ptr + k) % N);
        eg = '0;
        ep = '0;
        last = 0;
        if (order.size() > 0) begin
            a = order[0];
            eg[a] = 1'b1;
            last = a;
            ep[33:17] = {we[a], a_of(a), d_of(a)};
            if (order.size() > 1) begin
                b = order[1];
                if (a_of(a) == a_of(b) && (we[a] || we[b])) begin
                    if (upd && exp_coll < 65535) exp_coll++;
                end else begin
                    eg[b] = 1'b1;
                    last = b;
                    ep[16:0] = {we[b], a_of(b), d_of(b)};
                end
            end
        end
        obs_gnt = gnt;
        obs_ports = {write_en_a, address_a, data_in_a, write_en_b, address_b, data_in_b};
        chk("gnt", gnt, eg);
        chk("ports", obs_ports, ep);
        if (upd) begin
            for (int c = 0; c < N; c++)
                if (eg[c] && !we[c]) exp_q[c].push_back(ref_mem[a_of(c)]);
            for (int c = 0; c < N; c++)
                if (eg[c] && we[c]) ref_mem[a_of(c)] = d_of(c);
            if (eg != '0) ref_ptr = (last + 1) % N;
        end
    endtask

    task automatic step(input bit upd = 1'b1);
        @(negedge clk);
        obs_rvalid = rvalid;
        obs_rdata = rdata;
        model(upd);
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int c, input bit r, input bit w, input logic [7:0] a, input logic [7:0] d);
        req[c] = r;
        we[c] = w;
        addr[c*AW +: AW] = a;
        wdata[c*DW +: DW] = d;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                if (rvalid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL rvalid_unexpected client=%0d actual=1 expected=0 at %0t", i, $time);
                    end else begin
                        chk("rdata", rdata[i*DW +: DW], exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        req = '0; we = '0; addr = '0; wdata = '0;
        repeat (3) begin
            req = N'($urandom); we = N'($urandom); addr = $urandom; wdata = $urandom;
            step(1'b0);
        end
        req = '0;
        reset = 1'b1;
        step();
        chk("rst_rvalid", obs_rvalid, 0);
        chk("rst_rdata", obs_rdata, 0);
        chk("rst_ports", obs_ports, 0);

        set_client(0, 1, 1, 8'h01, 8'h11);
        set_client(1, 1, 1, 8'h02, 8'h22);
        step();
        chk("t2_wr_gnt", obs_gnt, 4'b0011);
        chk("t2_wr_ports", obs_ports, {1'b1, 8'h01, 8'h11, 1'b1, 8'h02, 8'h22});
        set_client(0, 1, 0, 8'h01, 8'h00);
        set_client(1, 1, 0, 8'h02, 8'h00);
        step();
        chk("t2_rd_gnt", obs_gnt, 4'b0011);
        req = '0;
        step();
        step();
        chk("t2_rvalid", obs_rvalid, 4'b0011);
        chk("t2_rdata", obs_rdata[15:0], 16'h2211);

        set_client(3, 1, 0, 8'h00, 8'h00);
        step();
        chk("t3_align_gnt", obs_gnt, 4'b1000);
        for (int c = 0; c < N; c++) set_client(c, 1, 0, 8'($urandom_range(0, 15)), 8'h00);
        for (int s = 0; s < 4; s++) begin
            step();
            chk("t3_rr_gnt", obs_gnt, (s % 2 == 0) ? 4'b0011 : 4'b1100);
        end
        req = '0;
        step();
        step();

        set_client(2, 1, 1, 8'h05, 8'h5A);
        set_client(3, 1, 0, 8'h05, 8'h00);
        step();
        chk("t4_hazard_gnt", obs_gnt, 4'b0100);
        chk("t4_hazard_ports", obs_ports, {1'b1, 8'h05, 8'h5A, 17'h0});
        req[2] = 1'b0;
        step();
        chk("t4_retry_gnt", obs_gnt, 4'b1000);
        req = '0;
        step();
        step();
        chk("t4_rvalid", obs_rvalid, 4'b1000);
        chk("t4_rdata", obs_rdata[31:24], 8'h5A);
        chk("t4_coll", collision_cnt, CNT_EN ? 1 : 0);

        set_client(0, 1, 0, 8'h01, 8'h00);
        set_client(1, 1, 0, 8'h01, 8'h00);
        step();
        chk("t5_rr_gnt", obs_gnt, 4'b0011);
        req = '0;
        step();
        step();
        chk("t5_rvalid", obs_rvalid, 4'b0011);
        chk("t5_rdata", obs_rdata[15:0], 16'h1111);

        set_client(0, 1, 0, 8'h02, 8'h00);
        @(negedge clk);
        chk("t6_gnt", gnt, 4'b0001);
        #2;
        reset = 1'b0;
        req = '0;
        for (int i = 0; i < N; i++) exp_q[i].delete();
        ref_ptr = 0;
        exp_coll = 0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("t6_no_rvalid", obs_rvalid, 0);
        end
        for (int c = 0; c < N; c++) set_client(c, 1, 0, 8'(c), 8'h00);
        step();
        chk("t6_ptr_gnt", obs_gnt, 4'b0011);
        req = '0;

        repeat (500) begin
            for (int c = 0; c < N; c++)
                if (!req[c] && $urandom_range(0, 9) < 6)
                    set_client(c, 1, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 7)), 8'($urandom));
            step();
            req = req & ~obs_gnt;
        end
        req = '0;
        repeat (4) step();
        for (int i = 0; i < N; i++) chk("drain_pending", exp_q[i].size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
